// File: rtl/mem_bus_seq.sv
// Shared 8-bit memory bus sequencer: two-byte PROM op fetch, decode slot, then
// at most one data load or store, with per-slot active-low strobes.

module mem_bus_strobe (
  input  logic clk,
  input  logic rst,
  input  logic rd_hit,
  input  logic wr_hit,
  output logic oe_n,
  output logic we_n
);
  always_ff @(posedge clk) begin
    if (rst) begin
      oe_n <= 1'b1;
      we_n <= 1'b1;
    end else begin
      oe_n <= ~rd_hit;
      we_n <= ~wr_hit;
    end
  end
endmodule

module mem_bus_seq #(
  parameter int MEM_WAIT = 2,
  parameter int N_DEV    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [15:0]      pc,
  input  logic [15:0]      mema,
  input  logic [2:0]       dev_sel,
  input  logic             is_load,
  input  logic             is_store,
  input  logic [7:0]       st_data,
  input  logic [7:0]       bus_rd,
  output logic [15:0]      addr,
  output logic [N_DEV-1:0] oe_n,
  output logic [N_DEV-1:0] we_n,
  output logic [7:0]       bus_wr,
  output logic             bus_drive,
  output logic [15:0]      op,
  output logic             op_valid,
  output logic             pc_inc,
  output logic [7:0]       ld_data,
  output logic             ld_valid,
  output logic             st_err,
  output logic             busy
);
  typedef enum logic [2:0] {IDLE, FETCH_LO, FETCH_HI, DECODE, MEM_RD, MEM_WR} state_t;

  typedef struct packed {
    logic [2:0]  dev;
    logic [15:0] mema;
    logic [7:0]  wdata;
  } acc_t;

  localparam logic [3:0] LAST_CNT = 4'(MEM_WAIT - 1);
  localparam logic [3:0] WAIT_CNT = 4'(MEM_WAIT);

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             hold, hold_nxt;
  logic             last;
  logic [7:0]       lo_byte;
  acc_t             acc, acc_nxt;
  logic             rd_en, wr_en;
  logic [2:0]       rd_dev;
  logic [N_DEV-1:0] rd_hit, wr_hit;

  assign last = (cnt == LAST_CNT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (run) state_nxt = FETCH_LO;
      FETCH_LO: if (last) state_nxt = FETCH_HI;
      FETCH_HI: if (last) state_nxt = DECODE;
      DECODE: begin
        if (is_load)       state_nxt = MEM_RD;
        else if (is_store) state_nxt = MEM_WR;
        else if (run)      state_nxt = FETCH_LO;
        else               state_nxt = IDLE;
      end
      MEM_RD:   if (last) state_nxt = run ? FETCH_LO : IDLE;
      MEM_WR:   if (hold) state_nxt = run ? FETCH_LO : IDLE;
      default:  state_nxt = IDLE;
    endcase

    cnt_nxt = (state_nxt != state) ? 4'd0 : ((cnt == 4'hF) ? cnt : cnt + 4'd1);
    // Separate hold flag: setup + MEM_WAIT strobes + hold can exceed the 4-bit count.
    hold_nxt = (state_nxt == MEM_WR) && (state == MEM_WR) && (hold || cnt == WAIT_CNT);
    acc_nxt  = (state == DECODE) ? '{dev: dev_sel, mema: mema, wdata: st_data} : acc;

    rd_en  = (state_nxt == FETCH_LO) || (state_nxt == FETCH_HI) || (state_nxt == MEM_RD);
    rd_dev = (state_nxt == MEM_RD) ? acc_nxt.dev : 3'd0;
    wr_en  = (state_nxt == MEM_WR) && (cnt_nxt != 4'd0) && !hold_nxt && (acc_nxt.dev != 3'd0);
  end

  for (genvar i = 0; i < N_DEV; i++) begin : g_hit
    assign rd_hit[i] = rd_en && (rd_dev == 3'(i));
    assign wr_hit[i] = wr_en && (acc_nxt.dev == 3'(i));
  end

  mem_bus_strobe u_strobe [N_DEV-1:0] (
    .clk    (clk),
    .rst    (rst),
    .rd_hit (rd_hit),
    .wr_hit (wr_hit),
    .oe_n   (oe_n),
    .we_n   (we_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      hold      <= 1'b0;
      acc       <= '0;
      lo_byte   <= 8'h00;
      op        <= 16'h0000;
      ld_data   <= 8'h00;
      op_valid  <= 1'b0;
      pc_inc    <= 1'b0;
      ld_valid  <= 1'b0;
      st_err    <= 1'b0;
      bus_drive <= 1'b0;
      bus_wr    <= 8'h00;
      busy      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hold  <= hold_nxt;
      acc   <= acc_nxt;
      if (state == FETCH_LO && last) lo_byte <= bus_rd;
      if (state == FETCH_HI && last) op <= {bus_rd, lo_byte};
      if (state == MEM_RD && last)   ld_data <= bus_rd;
      pc_inc    <= (state == FETCH_LO || state == FETCH_HI) && last;
      op_valid  <= (state_nxt == DECODE);
      ld_valid  <= (state == MEM_RD) && last;
      st_err    <= (state_nxt == MEM_WR) && (state != MEM_WR) && (acc_nxt.dev == 3'd0);
      bus_drive <= (state_nxt == MEM_WR);
      bus_wr    <= (state_nxt == MEM_WR) ? acc_nxt.wdata : 8'h00;
      busy      <= (state_nxt != IDLE);
    end
  end

  // pc passes straight through so the high byte sees the already-advanced PC.
  assign addr = (state == FETCH_LO || state == FETCH_HI) ? pc : acc.mema;

endmodule

// File: tb/tb_mem_bus_seq.sv
// Directed bench for mem_bus_seq: fetch, load, store, PROM-store error,
// reset mid-fetch and run-drop with load/store priority.

module tb_mem_bus_seq;
  logic        clk = 1'b0;
  logic        rst, run, is_load, is_store;
  logic [15:0] pc, mema, addr, op;
  logic [2:0]  dev_sel;
  logic [7:0]  st_data, bus_rd, bus_wr, ld_data, dev1_val;
  logic [7:0]  oe_n, we_n;
  logic        bus_drive, op_valid, pc_inc, ld_valid, st_err, busy;
  logic [7:0]  prom [0:7];
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_bus_seq #(.MEM_WAIT(2), .N_DEV(8)) dut (
    .clk(clk), .rst(rst), .run(run), .pc(pc), .mema(mema), .dev_sel(dev_sel),
    .is_load(is_load), .is_store(is_store), .st_data(st_data), .bus_rd(bus_rd),
    .addr(addr), .oe_n(oe_n), .we_n(we_n), .bus_wr(bus_wr), .bus_drive(bus_drive),
    .op(op), .op_valid(op_valid), .pc_inc(pc_inc), .ld_data(ld_data),
    .ld_valid(ld_valid), .st_err(st_err), .busy(busy)
  );

  // PC register and bus devices around the sequencer
  always @(posedge clk) begin
    if (rst)         pc <= 16'h0000;
    else if (pc_inc) pc <= pc + 16'h0001;
  end

  always_comb begin
    bus_rd = 8'h00;
    if (!oe_n[0])      bus_rd = prom[addr[2:0]];
    else if (!oe_n[1]) bus_rd = dev1_val;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; is_load = 1'b0; is_store = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic wait_opv(input string tag);
    int n = 0;
    while (!op_valid && n < 20) begin
      tick();
      n++;
    end
    chk(tag, op_valid, 1);
  endtask

  initial begin
    prom[0] = 8'h34; prom[1] = 8'h12; prom[2] = 8'h56; prom[3] = 8'h78;
    prom[4] = 8'hBC; prom[5] = 8'h9A; prom[6] = 8'h0F; prom[7] = 8'hE0;
    mema = 16'h0000; dev_sel = 3'd0; st_data = 8'h00; dev1_val = 8'hA5;

    // reset state, then plain fetch of 0x1234
    do_reset();
    chk("rst_oe", oe_n, 8'hFF);
    chk("rst_we", we_n, 8'hFF);
    chk("rst_busy", busy, 0);
    chk("rst_op", op, 16'h0000);
    chk("rst_drive", bus_drive, 0);
    chk("rst_ld", ld_data, 8'h00);
    run = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk($sformatf("t1_oe_c%0d", c), oe_n, (c <= 4) ? 8'hFE : 8'hFF);
      chk($sformatf("t1_pcinc_c%0d", c), pc_inc, (c == 3 || c == 5));
      chk($sformatf("t1_opv_c%0d", c), op_valid, (c == 5));
      chk($sformatf("t1_we_c%0d", c), we_n, 8'hFF);
      if (c == 2 || c == 4) chk($sformatf("t1_addr_c%0d", c), addr, (c == 4) ? 16'h0001 : 16'h0000);
    end
    chk("t1_op", op, 16'h1234);

    // load from slot 1; inputs changed mid-access must be ignored
    is_load = 1'b1; dev_sel = 3'd1; mema = 16'h8005;
    tick();
    chk("t2_oe1", oe_n, 8'hFD);
    chk("t2_addr1", addr, 16'h8005);
    chk("t2_busy", busy, 1);
    is_load = 1'b0; dev_sel = 3'd3; mema = 16'h0000;
    tick();
    chk("t2_oe2", oe_n, 8'hFD);
    chk("t2_addr2", addr, 16'h8005);
    chk("t2_ldv0", ld_valid, 0);
    tick();
    chk("t2_ldv1", ld_valid, 1);
    chk("t2_ld", ld_data, 8'hA5);
    chk("t2_refetch_oe", oe_n, 8'hFE);
    chk("t2_refetch_addr", addr, 16'h0002);
    tick();
    chk("t2_ldv_once", ld_valid, 0);

    // store to slot 2
    wait_opv("t3_opv");
    chk("t3_op", op, 16'h7856);
    is_store = 1'b1; dev_sel = 3'd2; st_data = 8'h5A;
    for (int w = 1; w <= 4; w++) begin
      tick();
      chk($sformatf("t3_drive_w%0d", w), bus_drive, 1);
      chk($sformatf("t3_we_w%0d", w), we_n, (w == 2 || w == 3) ? 8'hFB : 8'hFF);
      chk($sformatf("t3_oe_w%0d", w), oe_n, 8'hFF);
      chk($sformatf("t3_wr_w%0d", w), bus_wr, 8'h5A);
      chk($sformatf("t3_err_w%0d", w), st_err, 0);
      is_store = 1'b0; dev_sel = 3'd5; st_data = 8'hFF;
    end
    tick();
    chk("t3_drive_off", bus_drive, 0);
    chk("t3_next_oe", oe_n, 8'hFE);

    // store to PROM slot is suppressed
    wait_opv("t4_opv");
    chk("t4_op", op, 16'h9ABC);
    is_store = 1'b1; dev_sel = 3'd0; st_data = 8'h77;
    for (int w = 1; w <= 4; w++) begin
      tick();
      chk($sformatf("t4_we_w%0d", w), we_n, 8'hFF);
      chk($sformatf("t4_drive_w%0d", w), bus_drive, 1);
      chk($sformatf("t4_err_w%0d", w), st_err, (w == 1));
      is_store = 1'b0;
    end
    tick();
    chk("t4_drive_off", bus_drive, 0);
    chk("t4_next_oe", oe_n, 8'hFE);

    // run dropped during FETCH_LO; load wins over store; then idle
    run = 1'b0;
    wait_opv("t6_opv");
    chk("t6_op", op, 16'hE00F);
    is_load = 1'b1; is_store = 1'b1; dev_sel = 3'd1; mema = 16'h1234; dev1_val = 8'h3C;
    tick();
    chk("t6_oe1", oe_n, 8'hFD);
    chk("t6_we1", we_n, 8'hFF);
    chk("t6_drive1", bus_drive, 0);
    is_load = 1'b0; is_store = 1'b0;
    tick();
    chk("t6_oe2", oe_n, 8'hFD);
    tick();
    chk("t6_ldv", ld_valid, 1);
    chk("t6_ld", ld_data, 8'h3C);
    chk("t6_busy", busy, 0);
    chk("t6_oe_idle", oe_n, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t6_idle_oe%0d", k), oe_n, 8'hFF);
      chk($sformatf("t6_idle_we%0d", k), we_n, 8'hFF);
      chk($sformatf("t6_idle_busy%0d", k), busy, 0);
    end

    // reset in second FETCH_HI cycle aborts the fetch
    do_reset();
    run = 1'b1;
    repeat (4) tick();
    chk("t5_pre_oe", oe_n, 8'hFE);
    chk("t5_pre_addr", addr, 16'h0001);
    rst = 1'b1;
    tick();
    chk("t5_oe", oe_n, 8'hFF);
    chk("t5_busy", busy, 0);
    chk("t5_op", op, 16'h0000);
    chk("t5_opv", op_valid, 0);
    chk("t5_pcinc", pc_inc, 0);
    rst = 1'b0;
    tick();
    chk("t5_restart_oe", oe_n, 8'hFE);
    chk("t5_restart_addr", addr, 16'h0000);
    chk("t5_restart_busy", busy, 1);
    wait_opv("t5_opv2");
    chk("t5_op2", op, 16'h1234);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
